// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants and the hex-to-glyph decode for the seven-segment scanner.
//   SEG_BLANK  : all segments off (active-low).
//   GLYPHS     : 16 active-low {a..g} glyphs. Entry n is the glyph for hex digit n.
//   hex_to_seg : nibble -> active-low segment pattern. The table is total, so the
//                function needs no default.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Packed so that GLYPHS[n] selects the glyph for hex digit n.
    localparam logic [15:0][6:0] GLYPHS = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return GLYPHS[nib];
    endfunction

endpackage

// File: rtl/seven_seg_lz_mask.sv
// -----------------------------------------------------------------------------
// seven_seg_lz_mask
// Purely combinational leading-zero mask.
//   i_nibbles : N_DIGITS packed hex digits, nibble 0 is least significant.
//   i_lz_en   : 1 enables leading-zero blanking.
//   o_mask    : bit i set when digit i is a leading zero, i.e. every nibble from
//               i up to the top is zero. Bit 0 is never set so a zero value still
//               shows a single "0".
// -----------------------------------------------------------------------------
module seven_seg_lz_mask
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic [4*N_DIGITS-1:0] i_nibbles,
    input  logic                  i_lz_en,
    output logic [N_DIGITS-1:0]   o_mask
);

    logic w_zero_run;

    // Walk from the most significant digit down; w_zero_run stays 1 only while
    // every nibble seen so far (this one included) is zero.
    always_comb begin
        o_mask     = '0;
        w_zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (i_nibbles[4*i +: 4] == 4'h0);
            if (i != 0) begin
                o_mask[i] = i_lz_en & w_zero_run;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Each digit gets a slot of REFRESH_DIV clocks; the first BLANK_CYCLES of every
// slot drive all anodes off to avoid ghosting. Inputs are captured into shadow
// registers at the start of each frame so a changing value never shows torn.
//   clk         : system clock
//   reset       : asynchronous active-high reset
//   value       : packed hex digits, value[3:0] is digit 0 (rightmost)
//   dp_in       : per-digit decimal point request, 1 = lit
//   digit_en    : per-digit enable, 0 = anode never driven
//   lz_suppress : 1 enables leading-zero blanking
//   seg         : active-low segments {a..g}, seg[6] = a
//   dp          : active-low decimal point
//   an          : digit anodes, polarity from ANODE_ACTIVE_LOW
//   frame_tick  : one-cycle pulse following each shadow load
// -----------------------------------------------------------------------------
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS         = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int BLANK_CYCLES     = 64,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  lz_suppress,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam bit                  AN_LOW    = (ANODE_ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_OFF    = AN_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    // Scan state
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;

    // Shadow copies of the inputs, refreshed once per frame
    logic [4*N_DIGITS-1:0] r_value;
    logic [N_DIGITS-1:0]   r_dp;
    logic [N_DIGITS-1:0]   r_en;
    logic                  r_lz;

    // Registered outputs
    logic [6:0]            r_seg;
    logic                  r_dp_out;
    logic [N_DIGITS-1:0]   r_an;
    logic                  r_frame_tick;

    logic [N_DIGITS-1:0]   w_lz_mask;
    logic [N_DIGITS-1:0]   w_onehot;
    logic [3:0]            w_nib;
    logic                  w_dp_sel;
    logic                  w_suppress;
    logic                  w_blank;
    logic                  w_frame_start;
    logic [6:0]            w_seg_nxt;
    logic                  w_dp_nxt;
    logic [N_DIGITS-1:0]   w_an_nxt;

    seven_seg_lz_mask #(
        .N_DIGITS (N_DIGITS)
    ) u_lz_mask (
        .i_nibbles (r_value),
        .i_lz_en   (r_lz),
        .o_mask    (w_lz_mask)
    );

    assign w_frame_start = (r_idx == '0) && (r_cnt == '0);
    assign w_blank       = (r_cnt < CNT_BLANK);

    // Select the current digit's shadow data with an explicit compare per digit,
    // so a non-power-of-two N_DIGITS never indexes past the vectors.
    always_comb begin
        w_nib      = 4'h0;
        w_dp_sel   = 1'b0;
        w_suppress = 1'b1;
        w_onehot   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_value[4*i +: 4];
                w_dp_sel    = r_dp[i];
                w_suppress  = ~r_en[i] | w_lz_mask[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        if (w_blank || w_suppress) begin
            w_seg_nxt = SEG_BLANK;
            w_dp_nxt  = 1'b1;
            w_an_nxt  = AN_OFF;
        end else begin
            w_seg_nxt = hex_to_seg(w_nib);
            w_dp_nxt  = ~w_dp_sel;
            w_an_nxt  = AN_LOW ? ~w_onehot : w_onehot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_value      <= '0;
            r_dp         <= '0;
            r_en         <= '0;
            r_lz         <= 1'b0;
            r_seg        <= SEG_BLANK;
            r_dp_out     <= 1'b1;
            r_an         <= AN_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Frame start always lies inside the blank window, so swapping the
            // shadow here cannot disturb a lit digit.
            if (w_frame_start) begin
                r_value <= value;
                r_dp    <= dp_in;
                r_en    <= digit_en;
                r_lz    <= lz_suppress;
            end
            r_frame_tick <= w_frame_start;

            r_seg    <= w_seg_nxt;
            r_dp_out <= w_dp_nxt;
            r_an     <= w_an_nxt;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp_out;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
// Directed bench for seven_seg_scan with N_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2, active-low anodes. A frame is 32 clocks: four slots of
// 2 blank + 6 lit cycles. Inputs are driven and outputs sampled on the falling
// edge; each test starts one falling edge before a frame-load rising edge.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_suppress;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0111000;

    seven_seg_scan #(
        .N_DIGITS         (4),
        .REFRESH_DIV      (8),
        .BLANK_CYCLES     (2),
        .ANODE_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .lz_suppress (lz_suppress),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_tick  (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset       = 1'b1;
        value       = 16'h12AF;
        dp_in       = 4'h0;
        digit_en    = 4'hF;
        lz_suppress = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %b want %b", seg, 7'h7F); end
        n_checks++;
        if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b want 1", dp); end
        n_checks++;
        if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an got %b want 1111", an); end
        n_checks++;
        if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        logic [6:0] segs [4];
        logic [6:0] es;
        logic [3:0] ean;
        int d, ph;
        segs = '{GF, GA, G2, G1};
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); @(negedge clk);
            d = (k - 1) / 8; ph = (k - 1) % 8;
            es  = (ph < 2) ? 7'h7F : segs[d];
            ean = (ph < 2) ? 4'hF : ~(4'b0001 << d);
            n_checks++;
            if (seg !== es || an !== ean || dp !== 1'b1 || frame_tick !== (k == 1))
            begin
                n_fail++;
                $display("FAIL scan k=%0d got seg=%b an=%b dp=%b tick=%b want seg=%b an=%b dp=1 tick=%b",
                         k, seg, an, dp, frame_tick, es, ean, (k == 1));
            end
        end
    endtask

    task automatic test_lz_suppress();
        logic [6:0] segs [4];
        logic       lit  [4];
        logic [6:0] es;
        logic [3:0] ean;
        int d, ph;
        value = 16'h0050; lz_suppress = 1'b1;
        segs = '{G0, G5, G0, G0};
        lit  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); @(negedge clk);
            d = (k - 1) / 8; ph = (k - 1) % 8;
            es  = (ph < 2 || !lit[d]) ? 7'h7F : segs[d];
            ean = (ph < 2 || !lit[d]) ? 4'hF : ~(4'b0001 << d);
            n_checks++;
            if (seg !== es || an !== ean || frame_tick !== (k == 1)) begin
                n_fail++;
                $display("FAIL lz_0050 k=%0d got seg=%b an=%b tick=%b want seg=%b an=%b",
                         k, seg, an, frame_tick, es, ean);
            end
        end
    endtask

    task automatic test_all_zero();
        logic [6:0] es;
        logic [3:0] ean;
        int d, ph;
        value = 16'h0000; lz_suppress = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); @(negedge clk);
            d = (k - 1) / 8; ph = (k - 1) % 8;
            es  = (ph < 2 || d != 0) ? 7'h7F : G0;
            ean = (ph < 2 || d != 0) ? 4'hF : 4'b1110;
            n_checks++;
            if (seg !== es || an !== ean || frame_tick !== (k == 1)) begin
                n_fail++;
                $display("FAIL lz_0000 k=%0d got seg=%b an=%b want seg=%b an=%b", k, seg, an, es, ean);
            end
        end
    endtask

    task automatic test_digit_en();
        logic [6:0] segs [4];
        logic [6:0] es;
        logic [3:0] ean;
        int d, ph;
        value = 16'h12AF; lz_suppress = 1'b0; digit_en = 4'b0101;
        segs = '{GF, GA, G2, G1};
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); @(negedge clk);
            d = (k - 1) / 8; ph = (k - 1) % 8;
            es  = (ph < 2 || d == 1 || d == 3) ? 7'h7F : segs[d];
            ean = (ph < 2 || d == 1 || d == 3) ? 4'hF : ~(4'b0001 << d);
            n_checks++;
            if (seg !== es || an !== ean) begin
                n_fail++;
                $display("FAIL digit_en k=%0d got seg=%b an=%b want seg=%b an=%b", k, seg, an, es, ean);
            end
        end
        digit_en = 4'hF;
    endtask

    task automatic test_mid_frame();
        logic [6:0] es;
        logic [3:0] ean;
        int kk, d, ph;
        value = 16'h1111;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); @(negedge clk);
            kk = (k - 1) % 32; d = kk / 8; ph = kk % 8;
            es  = (ph < 2) ? 7'h7F : ((k <= 32) ? G1 : G2);
            ean = (ph < 2) ? 4'hF : ~(4'b0001 << d);
            n_checks++;
            if (seg !== es || an !== ean || frame_tick !== (kk == 0)) begin
                n_fail++;
                $display("FAIL mid_frame k=%0d got seg=%b an=%b tick=%b want seg=%b an=%b tick=%b",
                         k, seg, an, frame_tick, es, ean, (kk == 0));
            end
            if (k == 20) value = 16'h2222;
        end
    endtask

    task automatic test_dp();
        logic edp;
        int d, ph;
        value = 16'h12AF; dp_in = 4'b0100;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); @(negedge clk);
            d = (k - 1) / 8; ph = (k - 1) % 8;
            edp = (ph >= 2 && d == 2) ? 1'b0 : 1'b1;
            n_checks++;
            if (dp !== edp) begin
                n_fail++;
                $display("FAIL dp k=%0d got %b want %b", k, dp, edp);
            end
        end
        dp_in = 4'h0;
    endtask

    task automatic test_async_reset();
        logic [6:0] es;
        logic [3:0] ean;
        int d, ph;
        repeat (20) begin @(posedge clk); @(negedge clk); end
        n_checks++;
        if (an !== 4'b1011) begin n_fail++; $display("FAIL pre_reset_an got %b want 1011", an); end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got seg=%b dp=%b an=%b tick=%b want seg=1111111 dp=1 an=1111 tick=0",
                     seg, dp, an, frame_tick);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); @(negedge clk);
            d = (k - 1) / 8; ph = (k - 1) % 8;
            es  = (ph < 2) ? 7'h7F : ((d == 0) ? GF : GA);
            ean = (ph < 2) ? 4'hF : ~(4'b0001 << d);
            n_checks++;
            if (seg !== es || an !== ean || frame_tick !== (k == 1)) begin
                n_fail++;
                $display("FAIL restart k=%0d got seg=%b an=%b tick=%b want seg=%b an=%b tick=%b",
                         k, seg, an, frame_tick, es, ean, (k == 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz_suppress();
        test_all_zero();
        test_digit_en();
        test_mid_frame();
        test_dp();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Takes a packed hex value, per-digit decimal points and enables.
- Scans one digit at a time with a programmable refresh rate and an anti-ghosting blank interval.
- Optionally suppresses leading zeros. Sits between the height-measurement datapath and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 64, cycles at the start of each slot with all anodes off; legal range 1..REFRESH_DIV-1.
- ANODE_ACTIVE_LOW, 1, 1 means an[] is active-low, 0 means active-high.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- value  in  4*N_DIGITS  hex digits; value[3:0] is digit 0, the rightmost and least significant
- dp_in  in  N_DIGITS  decimal point request per digit, 1 means lit
- digit_en  in  N_DIGITS  per-digit enable; 0 means the anode is never driven for that digit
- lz_suppress  in  1  1 enables leading-zero blanking
- seg  out  7  segments {a,b,c,d,e,f,g}, seg[6]=a, active-low
- dp  out  1  decimal point segment, active-low
- an  out  N_DIGITS  digit anodes, polarity set by ANODE_ACTIVE_LOW
- frame_tick  out  1  one-cycle pulse at each frame start, when the shadow registers load

Behaviour:
- Clock and reset: clk is the single clock. reset is asynchronous, active-high.
- Reset values:
  - Prescaler cnt=0, digit index idx=0.
  - Shadow registers (value, dp, en, lz) = 0.
  - seg=7'h7F, dp=1, an all inactive, frame_tick=0.
- Prescaler: cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, idx increments modulo N_DIGITS.
  - N_DIGITS=1: idx stays 0.
- Shadow load:
  - When idx==0 and cnt==0, all inputs are captured into shadow registers. This includes the first cycle after reset deasserts.
  - The frame_tick register is set in that same cycle, so frame_tick is high in the following cycle only.
  - Input changes mid-frame have no effect until the next frame.
- Outputs: all registered. Outputs at cycle t+1 are a function of (idx, cnt, shadow) at cycle t.
- Blanking, when cnt < BLANK_CYCLES:
  - an all inactive, seg=7'h7F, dp=1.
  - The shadow load always falls inside blanking, so the new value is never displayed torn.
- Active phase, when cnt >= BLANK_CYCLES:
  - an[idx] active, all other anodes inactive.
  - seg = hex decode of shadow nibble idx. dp = ~shadow_dp[idx].
- Suppression: digit idx is suppressed when either condition holds:
  - shadow_en[idx]==0.
  - shadow_lz==1, idx!=0, and every nibble idx..N_DIGITS-1 equals 0.
- Suppressed digit: an stays inactive, seg=7'h7F, dp=1 for the whole slot. Digit 0 is never zero-suppressed.
- Hex decode, active-low {a..g}: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. The decode is total, so there is no default/latch case.
- Reset mid-scan: outputs go to reset values immediately (asynchronously). The scan restarts from digit 0 with a fresh shadow load.
- Widths:
  - cnt is $clog2(REFRESH_DIV) bits.
  - idx is max(1,$clog2(N_DIGITS)) bits.
  - Comparisons are unsigned with no truncation.

Decomposition:
- Package seven_seg_pkg holds:
  - SEG_BLANK = 7'h7F.
  - The 16-entry active-low glyph constant array.
  - The function hex_to_seg(logic[3:0]) returning logic[6:0].
- One sub-module, seven_seg_lz_mask. It is purely combinational: N nibbles in, N-bit suppress mask out. It keeps the leading-zero prefix-OR logic separately testable.
- Prescaler, scan index, shadow registers and output registers stay in the top module.

Test Plan (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=1):
- Reset then release with value=16'h12AF, digit_en=4'hF, lz=0 -> frame_tick high one cycle after release. Each slot shows 2 blank cycles then 6 active cycles. Slots in order: an=1110 seg=0111000, an=1101 seg=0001000, an=1011 seg=0010010, an=0111 seg=1001111. Frame period is 32 cycles.
- value=16'h0050, lz=1 -> digits 3 and 2 never drive an. Digit 1 shows 0100100, digit 0 shows 0000001.
- value=16'h0000, lz=1 -> only digit 0 is lit, showing 0000001. digit_en=4'b0101 with lz=0 -> an[1] and an[3] are never active.
- Change value from 16'h1111 to 16'h2222 while digit 2 is active -> digits 2 and 3 still show 1001111 this frame. All digits show 0010010 after the next frame_tick.
- dp_in=4'b0100 -> dp=0 only during digit 2 active cycles. dp=1 in blanking and in every other slot.
- Assert reset asynchronously mid-slot of digit 2 -> same-cycle seg=7F, dp=1, an=1111. After release the scan restarts at digit 0 with frame_tick.
